// File: rtl/alpha_recursion_ctrl.sv
// alpha_recursion_ctrl: sequences the forward (alpha) recursion of the
// max-product SISO decoder. One trellis step at a time it fetches branch
// metrics, launches the alpha datapath, waits for its result, feeds it back
// as previous alpha and streams every alpha vector to the alpha memory.
module alpha_recursion_ctrl #(
  parameter int unsigned    BITS      = 16,
  parameter int unsigned    STATES    = 8,
  parameter int unsigned    ADDR_BITS = 10,
  parameter logic [BITS-1:0] NEG_INF  = 16'hFC00,
  parameter logic [BITS-1:0] ZERO     = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_BITS-1:0]     frame_len,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     bm_rd_en,
  output logic [ADDR_BITS-1:0]     bm_rd_addr,
  output logic                     dp_in_valid,
  output logic [BITS*STATES-1:0]   dp_prev_alpha,
  input  logic                     dp_out_valid,
  input  logic [BITS*STATES-1:0]   dp_alpha,
  output logic                     alpha_wr_en,
  output logic [ADDR_BITS-1:0]     alpha_wr_addr,
  output logic [BITS*STATES-1:0]   alpha_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FETCH,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                   state;
  state_t                   next_state;

  logic [ADDR_BITS-1:0]     step;
  logic [ADDR_BITS-1:0]     step_nxt;
  logic [ADDR_BITS-1:0]     len;
  logic [BITS*STATES-1:0]   prev_alpha;
  logic [BITS*STATES-1:0]   init_vec;
  logic                     wr_en_q;
  logic [ADDR_BITS-1:0]     wr_addr_q;
  logic                     zero_done_q;

  logic                     accept;
  logic                     zero_start;
  logic                     init_load;
  logic                     capture;
  logic                     done_state;

  assign step_nxt = step + ADDR_BITS'(1);

  // Starting metrics: state 0 is certain, all others impossible.
  always_comb begin
    init_vec = '0;
    for (int unsigned i = 0; i < STATES; i++) begin
      init_vec[i*BITS +: BITS] = (i == 0) ? ZERO : NEG_INF;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and per-state strobes; abort overrides every transition.
  always_comb begin
    next_state  = state;
    busy        = 1'b0;
    bm_rd_en    = 1'b0;
    dp_in_valid = 1'b0;
    done_state  = 1'b0;
    accept      = 1'b0;
    zero_start  = 1'b0;
    init_load   = 1'b0;
    capture     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            accept     = 1'b1;
            next_state = S_INIT;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      S_INIT: begin
        busy       = 1'b1;
        init_load  = 1'b1;
        next_state = S_FETCH;
      end
      S_FETCH: begin
        busy       = 1'b1;
        bm_rd_en   = 1'b1;
        next_state = S_LAUNCH;
      end
      S_LAUNCH: begin
        busy        = 1'b1;
        dp_in_valid = 1'b1;
        next_state  = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (dp_out_valid) begin
          capture    = 1'b1;
          next_state = (step_nxt == len) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        done_state = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (abort) begin
      next_state = S_IDLE;
      accept     = 1'b0;
      zero_start = 1'b0;
      init_load  = 1'b0;
      capture    = 1'b0;
    end
  end

  // Step counter, frame length latch, previous-alpha feedback and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      step        <= '0;
      len         <= '0;
      prev_alpha  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      zero_done_q <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      zero_done_q <= zero_start;
      if (accept) begin
        len  <= frame_len;
        step <= '0;
      end
      if (init_load) begin
        prev_alpha <= init_vec;
        wr_en_q    <= 1'b1;
        wr_addr_q  <= '0;
      end
      if (capture) begin
        prev_alpha <= dp_alpha;
        wr_en_q    <= 1'b1;
        wr_addr_q  <= step_nxt;
        if (next_state == S_FETCH) begin
          step <= step_nxt;
        end
      end
    end
  end

  // Sticky error: a datapath result arriving when none is awaited.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (dp_out_valid && state != S_WAIT) begin
      err <= 1'b1;
    end else if (accept) begin
      err <= 1'b0;
    end
  end

  assign done          = done_state | zero_done_q;
  assign bm_rd_addr    = step;
  assign dp_prev_alpha = prev_alpha;
  assign alpha_wr_en   = wr_en_q;
  assign alpha_wr_addr = wr_addr_q;
  assign alpha_wr_data = prev_alpha;

endmodule
